// File: rtl/universal_shift_register_if.sv
// Bus bundle for universal_shift_register: controls, data, serial taps and burst status.
interface universal_shift_register_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [2:0]       mode;
  logic             start;
  logic [WIDTH-1:0] Din;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] Q;
  logic             sout_lsb;
  logic             sout_msb;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, start, Din, sin_l, sin_r,
    input  Q, sout_lsb, sout_msb, busy, done
  );

  modport slave (
    input  en, mode, start, Din, sin_l, sin_r,
    output Q, sout_lsb, sout_msb, busy, done
  );
endinterface

// File: rtl/universal_shift_register.sv
// Universal shift register with a self-timed LSB-first burst serializer.
// Optional rotate modes are built only when USR_ROTATE_EN is defined.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | manual ops by mode; start loads Din and begins a burst
// S_SHIFT | burst streaming, Q[0] is the serial output; busy=1
// S_DONE  | one-cycle completion pulse; may accept a new start
module universal_shift_register #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  universal_shift_register_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      q     <= '0;
    end else begin
      case (state)
        S_SHIFT: begin
          if (bus.en) begin
            // The last bit is already on Q[0]; hold it for its busy cycle.
            if (cnt < LAST) begin
              q   <= {bus.sin_r, q[WIDTH-1:1]};
              cnt <= cnt + 1'b1;
            end else begin
              state <= S_DONE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          if (bus.en) begin
            if (bus.start) begin
              q     <= bus.Din;
              cnt   <= '0;
              state <= S_SHIFT;
            end else begin
              case (bus.mode)
                3'b001: q <= {q[WIDTH-2:0], bus.sin_l};
                3'b010: q <= {bus.sin_r, q[WIDTH-1:1]};
                3'b011: q <= bus.Din;
`ifdef USR_ROTATE_EN
                3'b100: q <= {q[WIDTH-2:0], q[WIDTH-1]};
                3'b101: q <= {q[0], q[WIDTH-1:1]};
`endif
                default: q <= q;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign bus.Q        = q;
  assign bus.sout_lsb = q[0];
  assign bus.sout_msb = q[WIDTH-1];
  assign bus.busy     = (state == S_SHIFT);
  assign bus.done     = (state == S_DONE);

endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised universal shift register, the successor to the fixed 4-bit parallel-in/parallel-out register. It supports hold, shift left, shift right, parallel load and rotate under a mode select. It also has a self-timed burst serializer that loads a word and streams it out LSB-first with busy/done status. It is used wherever the design needs configurable-width storage or parallel-to-serial conversion.

## Interface
Parameters:
- WIDTH, 4, register width in bits; legal range 2 to 64.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  operation enable; 0 freezes the register and the burst.
- mode  in  3  manual operation select.
- start  in  1  burst request; sampled on the rising edge.
- Din  in  WIDTH  parallel data input.
- sin_l  in  1  serial input; enters bit 0 on a left shift.
- sin_r  in  1  serial input; enters bit WIDTH-1 on a right shift or during a burst.
- Q  out  WIDTH  register contents.
- sout_lsb  out  1  equals Q[0]; this is the burst serial output.
- sout_msb  out  1  equals Q[WIDTH-1].
- busy  out  1  high while a burst is streaming.
- done  out  1  one-cycle pulse after a burst completes.

## Operation
- State machine has three states: IDLE, SHIFT, DONE.
- Internal bit counter width: $clog2(WIDTH)+1.
- Mode encoding, applied in IDLE or DONE when en=1 and start=0:
  - 000 HOLD.
  - 001 SHL: Q <= {Q[WIDTH-2:0], sin_l}.
  - 010 SHR: Q <= {sin_r, Q[WIDTH-1:1]}.
  - 011 LOAD: Q <= Din.
  - 100 ROTL: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - 101 ROTR: Q <= {Q[0], Q[WIDTH-1:1]}.
  - 110, 111: HOLD.
- Priority per edge: rst, then the SHIFT-state burst, then start, then mode.
- start with en=1 in IDLE or DONE:
  - Q <= Din, counter <= 0, next state SHIFT.
  - mode is ignored on that edge.
- start with en=0 is dropped, not queued.
- start while in SHIFT is ignored and has no effect on the burst in progress.
- SHIFT state, en=1:
  - If counter < WIDTH-1: Q <= {sin_r, Q[WIDTH-1:1]} and counter increments.
  - If counter = WIDTH-1: Q holds and next state is DONE.
- SHIFT state, en=0: Q, counter and state are all frozen; busy stays high.
- In SHIFT, mode and Din are ignored.
- DONE lasts exactly one cycle. It returns to IDLE unless a start is accepted on that edge.
- busy = (state == SHIFT). done = (state == DONE). Both are registered-state decodes with no combinational input paths.

## Timing
- Reset: the edge with rst=1 sets Q=0, state=IDLE, counter=0. Resulting outputs: busy=0, done=0, sout_lsb=0, sout_msb=0.
- Reset mid-burst aborts the burst. No done pulse is produced.
- Manual ops have 1-cycle latency: the result is visible on Q after the sampling edge.
- Burst accepted at edge t0:
  - busy is high from t0 for WIDTH enabled cycles, indexed k=0..WIDTH-1.
  - In busy cycle k, sout_lsb = Din[k] as sampled at t0.
  - done is high in the cycle after the final busy cycle.
  - After the burst, Q[0] = Din[WIDTH-1] and the upper bits hold the captured sin_r values.
- Stalls (en=0) stretch busy one cycle per stalled cycle. They do not corrupt data order.
- Back-to-back bursts: start during DONE gives busy high again on the very next cycle. done and busy are never high in the same cycle.

## Configuration
- USR_ROTATE_EN defined: the ROTL (100) and ROTR (101) modes are implemented as specified.
- USR_ROTATE_EN undefined: codes 100 and 101 decode as HOLD. No rotate logic is synthesised. All other behaviour is unchanged.

## Test plan
All scenarios use WIDTH=4.
- Reset: drive rst=1 for one edge with arbitrary inputs -> Q=0000, busy=0, done=0. Then LOAD Din=1011 -> Q=1011 on the next edge.
- Shifts: from Q=1011, SHL with sin_l=0 -> 0110; SHR with sin_r=1 -> 1011; HOLD with en=0 and mode=LOAD -> Q unchanged.
- Rotate, with USR_ROTATE_EN defined: Q=1001, ROTL -> 0011, then ROTR -> 1001. Without the macro, ROTL leaves Q=1001.
- Burst: start with Din=0110 and sin_r=0 -> busy high for 4 cycles, sout_lsb sequence 0,1,1,0, then done high for 1 cycle, Q=0000.
- Stall and ignore: during a burst, drop en for 2 cycles -> busy lasts 6 cycles and the sout_lsb sequence is unchanged. A start pulsed mid-burst is ignored.
- Back-to-back and abort:
  - Start during done -> a new burst begins on the next cycle with fresh Din.
  - rst asserted in busy cycle 2 -> Q=0000, IDLE, no done pulse.
